// File: rtl/rom_dumper_pkg.sv
// rom_dumper_pkg: shared definitions for the ROM dumper.
//   - geometry constants (region count, SDRAM address width)
//   - dump_region_t and the DUMP_REGIONS table (base/bram_cs match the
//     loader's region table; bram_cs != 0 marks a BRAM-resident region)
//   - stream-format constants
//   - FSM state encodings for the top FSM and the byte-fetch path
package rom_dumper_pkg;

    localparam int unsigned NUM_REGIONS = 16;
    localparam int unsigned REGION_W    = 4;
    localparam int unsigned ADDR_W      = 25;

    // Stream format: header is index byte + 3-byte big-endian size.
    localparam int unsigned HDR_SIZE_BYTES = 3;
    // Reserved as the loader's end marker; the dumper never emits it.
    localparam logic [7:0]  END_MARK       = 8'hff;

    typedef struct packed {
        logic [24:0] base_addr;
        logic [23:0] size;
        logic [5:0]  bram_cs;
    } dump_region_t;

    localparam dump_region_t DUMP_REGIONS [NUM_REGIONS] = '{
        '{base_addr: 25'h0000000, size: 24'h000010, bram_cs: 6'h00},
        '{base_addr: 25'h0080000, size: 24'h000800, bram_cs: 6'h01},
        '{base_addr: 25'h0100000, size: 24'h000004, bram_cs: 6'h00},
        '{base_addr: 25'h0180000, size: 24'h000000, bram_cs: 6'h00},
        '{base_addr: 25'h1fffffe, size: 24'h000003, bram_cs: 6'h00},
        '{base_addr: 25'h0200000, size: 24'h010000, bram_cs: 6'h00},
        '{base_addr: 25'h0400000, size: 24'h040000, bram_cs: 6'h00},
        '{base_addr: 25'h0800000, size: 24'h100000, bram_cs: 6'h00},
        '{base_addr: 25'h0c00000, size: 24'h020000, bram_cs: 6'h00},
        '{base_addr: 25'h0000000, size: 24'h000400, bram_cs: 6'h02},
        '{base_addr: 25'h0000000, size: 24'h000400, bram_cs: 6'h04},
        '{base_addr: 25'h0000000, size: 24'h000000, bram_cs: 6'h3f},
        '{base_addr: 25'h0000000, size: 24'h000000, bram_cs: 6'h3f},
        '{base_addr: 25'h0000000, size: 24'h000000, bram_cs: 6'h3f},
        '{base_addr: 25'h0000000, size: 24'h000000, bram_cs: 6'h3f},
        '{base_addr: 25'h0000000, size: 24'h000000, bram_cs: 6'h3f}
    };

    // Top FSM states
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_CFG   = 4'd1;
    localparam logic [3:0] ST_NEXT  = 4'd2;
    localparam logic [3:0] ST_IDX   = 4'd3;
    localparam logic [3:0] ST_SZ0   = 4'd4;
    localparam logic [3:0] ST_SZ1   = 4'd5;
    localparam logic [3:0] ST_SZ2   = 4'd6;
    localparam logic [3:0] ST_FETCH = 4'd7;
    localparam logic [3:0] ST_DATA  = 4'd8;
    localparam logic [3:0] ST_FIN   = 4'd9;

    // Byte-fetch path phases
    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_FETCH = 2'd1;
    localparam logic [1:0] PH_DATA  = 2'd2;

    function automatic logic [7:0] idx_byte(input logic [REGION_W-1:0] r);
        return {4'h0, r};
    endfunction

endpackage

// File: rtl/rom_dumper_if.sv
// rom_dumper_if: byte-stream output and SDRAM read request port of the
// ROM dumper.
//   out_data/out_valid/out_ready : byte stream, valid/ready handshake
//   sdr_addr/sdr_req             : read request (level, held until sdr_rdy)
//   sdr_rdy/sdr_q                : read completion pulse and data word
// master = dumper side, slave = sink/SDRAM side.
interface rom_dumper_if;
    import rom_dumper_pkg::*;

    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] sdr_addr;
    logic              sdr_req;
    logic              sdr_rdy;
    logic [15:0]       sdr_q;

    modport master (
        output out_data, out_valid, sdr_addr, sdr_req,
        input  out_ready, sdr_rdy, sdr_q
    );

    modport slave (
        input  out_data, out_valid, sdr_addr, sdr_req,
        output out_ready, sdr_rdy, sdr_q
    );

endinterface

// File: rtl/rom_dump_byte_fetch.sv
// rom_dump_byte_fetch: turns a region offset into one data byte.
//   clk_i/rst_ni      : clock, async active-low reset
//   inv_i             : invalidate the word cache (region start)
//   base_i            : region base byte address
//   off_valid_i/off_i/off_ready_o : offset request (accepted when idle)
//   byte_valid_o/byte_o/byte_ready_i : byte result handshake
//   sdr_addr_o/sdr_req_o/sdr_rdy_i/sdr_q_i : SDRAM read port
// An SDRAM word is fetched for offset 0, for even addresses, or when the
// cache is invalid; odd addresses reuse the cached word's high byte.
module rom_dump_byte_fetch
    import rom_dumper_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inv_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              off_valid_i,
    input  logic [23:0]       off_i,
    output logic              off_ready_o,
    output logic              byte_valid_o,
    output logic [7:0]        byte_o,
    input  logic              byte_ready_i,
    output logic [ADDR_W-1:0] sdr_addr_o,
    output logic              sdr_req_o,
    input  logic              sdr_rdy_i,
    input  logic [15:0]       sdr_q_i
);

    logic [1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cache_q, cache_d;
    logic              cvld_q, cvld_d;

    logic [ADDR_W-1:0] addr_next;
    logic              need_fetch;

    // Address wraps modulo 2^ADDR_W by truncation.
    assign addr_next  = base_i + ADDR_W'(off_i);
    assign need_fetch = (off_i == '0) || !addr_next[0] || !cvld_q;

    always_comb begin
        phase_d = phase_q;
        addr_d  = addr_q;
        cache_d = cache_q;
        cvld_d  = cvld_q;
        if (inv_i) begin
            cvld_d = 1'b0;
        end
        case (phase_q)
            PH_IDLE: begin
                if (off_valid_i) begin
                    addr_d  = addr_next;
                    phase_d = need_fetch ? PH_FETCH : PH_DATA;
                end
            end
            PH_FETCH: begin
                if (sdr_rdy_i) begin
                    cache_d = sdr_q_i;
                    cvld_d  = 1'b1;
                    phase_d = PH_DATA;
                end
            end
            PH_DATA: begin
                if (byte_ready_i) begin
                    phase_d = PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PH_IDLE;
            addr_q  <= '0;
            cache_q <= '0;
            cvld_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            addr_q  <= addr_d;
            cache_q <= cache_d;
            cvld_q  <= cvld_d;
        end
    end

    assign off_ready_o  = (phase_q == PH_IDLE);
    assign byte_valid_o = (phase_q == PH_DATA);
    assign byte_o       = addr_q[0] ? cache_q[15:8] : cache_q[7:0];
    assign sdr_addr_o   = addr_q;
    assign sdr_req_o    = (phase_q == PH_FETCH);

endmodule

// File: rtl/rom_dumper.sv
// rom_dumper: walks the DUMP_REGIONS table and re-emits selected
// SDRAM-resident regions in the ROM loader's input format:
//   board_cfg, then per region: index, size[23:16], size[15:8], size[7:0], data.
//   sys_clk/reset_n : clock, async active-low reset
//   start           : dump request pulse (ignored while busy)
//   region_mask     : bit i selects region i (sampled on accepted start)
//   board_cfg       : first stream byte (sampled on accepted start)
//   busy/done       : dump in progress / one-cycle completion pulse
//   bus             : byte stream + SDRAM read port (rom_dumper_if.master)
// The FSM here emits headers; data bytes come from rom_dump_byte_fetch.
module rom_dumper
    import rom_dumper_pkg::*;
(
    input  logic                   sys_clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [NUM_REGIONS-1:0] region_mask,
    input  logic [7:0]             board_cfg,
    output logic                   busy,
    output logic                   done,
    rom_dumper_if.master           bus
);

    logic [3:0]             state_q, state_d;
    logic [REGION_W-1:0]    region_q, region_d;
    logic [NUM_REGIONS-1:0] mask_q, mask_d;
    logic [7:0]             cfg_q, cfg_d;
    logic [23:0]            off_q, off_d;

    dump_region_t cur;
    logic         last_region;

    logic       out_valid, inv, off_valid, off_ready;
    logic       byte_valid, byte_ready;
    logic [7:0] out_data, byte_data;

    assign cur         = DUMP_REGIONS[region_q];
    assign last_region = (region_q == REGION_W'(NUM_REGIONS - 1));

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        mask_d     = mask_q;
        cfg_d      = cfg_q;
        off_d      = off_q;
        out_valid  = 1'b0;
        out_data   = '0;
        inv        = 1'b0;
        off_valid  = 1'b0;
        byte_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d   = region_mask;
                    cfg_d    = board_cfg;
                    region_d = '0;
                    state_d  = ST_CFG;
                end
            end
            ST_CFG: begin
                out_valid = 1'b1;
                out_data  = cfg_q;
                if (bus.out_ready) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (mask_q[region_q] && (cur.bram_cs == '0)) begin
                    state_d = ST_IDX;
                end else if (last_region) begin
                    state_d = ST_FIN;
                end else begin
                    region_d = region_q + 4'd1;
                end
            end
            ST_IDX: begin
                out_valid = 1'b1;
                out_data  = idx_byte(region_q);
                if (bus.out_ready) state_d = ST_SZ0;
            end
            ST_SZ0: begin
                out_valid = 1'b1;
                out_data  = cur.size[23:16];
                if (bus.out_ready) state_d = ST_SZ1;
            end
            ST_SZ1: begin
                out_valid = 1'b1;
                out_data  = cur.size[15:8];
                if (bus.out_ready) state_d = ST_SZ2;
            end
            ST_SZ2: begin
                out_valid = 1'b1;
                out_data  = cur.size[7:0];
                if (bus.out_ready) begin
                    if (cur.size == '0) begin
                        if (last_region) state_d = ST_FIN;
                        else begin
                            region_d = region_q + 4'd1;
                            state_d  = ST_NEXT;
                        end
                    end else begin
                        off_d   = '0;
                        inv     = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            // Hands the current offset to the fetch path; that path decides
            // whether an SDRAM read is actually needed.
            ST_FETCH: begin
                off_valid = 1'b1;
                if (off_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                out_valid  = byte_valid;
                out_data   = byte_data;
                byte_ready = bus.out_ready;
                if (byte_valid && bus.out_ready) begin
                    if (off_q == cur.size - 24'd1) begin
                        if (last_region) state_d = ST_FIN;
                        else begin
                            region_d = region_q + 4'd1;
                            state_d  = ST_NEXT;
                        end
                    end else begin
                        off_d   = off_q + 24'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            region_q <= '0;
            mask_q   <= '0;
            cfg_q    <= '0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            mask_q   <= mask_d;
            cfg_q    <= cfg_d;
            off_q    <= off_d;
        end
    end

    rom_dump_byte_fetch u_fetch (
        .clk_i        (sys_clk),
        .rst_ni       (reset_n),
        .inv_i        (inv),
        .base_i       (cur.base_addr),
        .off_valid_i  (off_valid),
        .off_i        (off_q),
        .off_ready_o  (off_ready),
        .byte_valid_o (byte_valid),
        .byte_o       (byte_data),
        .byte_ready_i (byte_ready),
        .sdr_addr_o   (bus.sdr_addr),
        .sdr_req_o    (bus.sdr_req),
        .sdr_rdy_i    (bus.sdr_rdy),
        .sdr_q_i      (bus.sdr_q)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done          = (state_q == ST_FIN);

endmodule

// File: tb/tb_rom_dumper.sv
// tb_rom_dumper: directed bench for rom_dumper with an SDRAM responder,
// a sink with programmable ready pattern, and stream capture.
module tb_rom_dumper;
    import rom_dumper_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] region_mask;
    logic [7:0]  board_cfg;
    logic        busy, done;

    rom_dumper_if bus();

    rom_dumper dut (
        .sys_clk     (clk),
        .reset_n     (reset_n),
        .start       (start),
        .region_mask (region_mask),
        .board_cfg   (board_cfg),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Sink / SDRAM environment controls
    bit          ready_mode = 1'b0;
    int unsigned sdr_delay  = 0;
    logic [3:0]  pat        = 4'b1001;   // 1,0,0,1 from bit 0 upward
    int unsigned pidx       = 0;

    // Observations
    logic [7:0]        got[$];
    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] req_addrs[$];
    int unsigned       req_cnt    = 0;
    int unsigned       done_cnt   = 0;
    int unsigned       stall_viol = 0;
    int unsigned       wait_cnt   = 0;
    bit                req_prev   = 1'b0;
    bit                stalled    = 1'b0;
    logic [7:0]        stall_data = '0;

    function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
        case ({a[ADDR_W-1:1], 1'b0})
            25'h0100000: return 16'h2211;
            25'h0100002: return 16'h4433;
            25'h1fffffe: return 16'hbbaa;
            25'h0000000: return 16'hddcc;
            default:     return 16'hdead;
        endcase
    endfunction

    always @(negedge clk) begin
        if (ready_mode) begin
            bus.out_ready = pat[pidx];
            pidx = (pidx + 1) % 4;
        end else begin
            bus.out_ready = 1'b1;
        end
        if (!reset_n) begin
            bus.sdr_rdy = 1'b0;
            bus.sdr_q   = '0;
            wait_cnt    = 0;
            req_prev    = 1'b0;
            stalled     = 1'b0;
        end else begin
            if (bus.sdr_req && !req_prev) begin
                req_cnt++;
                req_addrs.push_back(bus.sdr_addr);
            end
            req_prev = bus.sdr_req;
            if (bus.sdr_rdy) begin
                bus.sdr_rdy = 1'b0;
                wait_cnt    = 0;
            end else if (bus.sdr_req) begin
                if (wait_cnt >= sdr_delay) begin
                    bus.sdr_rdy = 1'b1;
                    bus.sdr_q   = mem_word(bus.sdr_addr);
                end else begin
                    wait_cnt++;
                end
            end
            if (stalled && (!bus.out_valid || bus.out_data !== stall_data)) stall_viol++;
            stalled    = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stream(input string tag);
        logic [31:0] obs;
        chk({tag, " len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got.size()) ? {24'h0, got[i]} : 'x;
            chk($sformatf("%s byte%0d", tag, i), obs, {24'h0, exp_q[i]});
        end
    endtask

    task automatic pulse_start(input logic [15:0] m, input logic [7:0] c);
        @(negedge clk);
        region_mask = m;
        board_cfg   = c;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned base);
        int unsigned n = 0;
        while (done_cnt == base && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, " done seen"}, 32'(done_cnt != base), 32'd1);
        repeat (5) @(posedge clk);
    endtask

    task automatic clear_obs();
        got.delete();
        req_addrs.delete();
        req_cnt    = 0;
        done_cnt   = 0;
        stall_viol = 0;
    endtask

    initial begin
        int unsigned n;
        reset_n     = 1'b0;
        start       = 1'b0;
        region_mask = '0;
        board_cfg   = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_data", bus.out_data, 0);
        chk("rst sdr_req", bus.sdr_req, 0);
        chk("rst sdr_addr", bus.sdr_addr, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);

        // Basic dump of region 2
        clear_obs();
        pulse_start(16'h0004, 8'h5a);
        chk("t1 busy after start", busy, 1);
        wait_done("t1", 0);
        exp_q = '{8'h5a, 8'h02, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        chk_stream("t1");
        chk("t1 sdr_req count", req_cnt, 2);
        chk("t1 done count", done_cnt, 1);
        chk("t1 busy idle", busy, 0);

        // Same with stalling sink and slow SDRAM
        clear_obs();
        ready_mode = 1'b1;
        sdr_delay  = 7;
        pulse_start(16'h0004, 8'h5a);
        wait_done("t2", 0);
        chk_stream("t2");
        chk("t2 sdr_req count", req_cnt, 2);
        chk("t2 done count", done_cnt, 1);
        chk("t2 stall stability", stall_viol, 0);
        ready_mode = 1'b0;
        sdr_delay  = 0;

        // Size-0 region 3 plus BRAM region 1
        clear_obs();
        pulse_start(16'h000a, 8'hc3);
        wait_done("t3", 0);
        exp_q = '{8'hc3, 8'h03, 8'h00, 8'h00, 8'h00};
        chk_stream("t3");
        chk("t3 sdr_req count", req_cnt, 0);

        // Address wrap at top of SDRAM
        clear_obs();
        pulse_start(16'h0010, 8'h77);
        wait_done("t4", 0);
        exp_q = '{8'h77, 8'h04, 8'h00, 8'h00, 8'h03, 8'haa, 8'hbb, 8'hcc};
        chk_stream("t4");
        chk("t4 sdr_req count", req_cnt, 2);
        chk("t4 fetch addr0", (req_addrs.size() > 0) ? 32'(req_addrs[0]) : 'x, 32'h1fffffe);
        chk("t4 fetch addr1", (req_addrs.size() > 1) ? 32'(req_addrs[1]) : 'x, 32'h0000000);

        // Empty mask, with start pulses while busy
        clear_obs();
        pulse_start(16'h0000, 8'he1);
        pulse_start(16'h0004, 8'h99);
        pulse_start(16'h0004, 8'h98);
        wait_done("t5", 0);
        repeat (20) @(posedge clk);
        exp_q = '{8'he1};
        chk_stream("t5");
        chk("t5 done count", done_cnt, 1);
        chk("t5 sdr_req count", req_cnt, 0);

        // Reset mid-DATA, then restart
        clear_obs();
        ready_mode = 1'b1;
        sdr_delay  = 7;
        pulse_start(16'h0004, 8'h5a);
        n = 0;
        while (got.size() < 6 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("t6 reached data", 32'(got.size() >= 6), 32'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 rst out_valid", bus.out_valid, 0);
        chk("t6 rst out_data", bus.out_data, 0);
        chk("t6 rst sdr_req", bus.sdr_req, 0);
        chk("t6 rst sdr_addr", bus.sdr_addr, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst done", done, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("t6 no done after abort", done_cnt, 0);
        clear_obs();
        ready_mode = 1'b0;
        sdr_delay  = 0;
        pulse_start(16'h0004, 8'h3c);
        wait_done("t6", 0);
        exp_q = '{8'h3c, 8'h02, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        chk_stream("t6");
        chk("t6 done count", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
